hazard_scoreboard: RTL and testbench

- Next-generation hazard unit for the in-order RV64 pipeline.
- Generalises load-use detection to a parametrised load latency.
- Adds a register scoreboard for long-latency producers (div, multi-cycle mul, uncached loads) with RAW and WAW stalls.
- Handles branch-flush priority and keeps a saturating stall-cycle counter.
- Sits beside the decode stage and drives the IF/ID/EX stall and flush controls.

---
 rtl/hazard_pkg.sv | 21 ++
 rtl/hazard_load_window.sv | 60 ++++++
 rtl/hazard_scoreboard.sv | 138 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg : shared register-address and load-window types for the hazard unit
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam int HZ_NUM_REGS = 32;
  localparam int HZ_ADDR_W   = $clog2(HZ_NUM_REGS);

  typedef logic [HZ_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } ld_stage_t;

endpackage

`default_nettype wire

// File: rtl/hazard_load_window.sv
// ---------------------------------------------------------------------------
// hazard_load_window : LOAD_LAT-deep {valid, rd} shift register with per-source match
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_load_window
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int NUM_SRC  = 2,
  parameter int ADDR_W   = HZ_ADDR_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      ld_valid_i,
  input  logic [ADDR_W-1:0]         ld_rd_i,
  input  logic [NUM_SRC*ADDR_W-1:0] rs_addr_i,
  input  logic [NUM_SRC-1:0]        rs_used_i,
  output logic [NUM_SRC-1:0]        hit_o
);

  ld_stage_t [LOAD_LAT-1:0] stage_q;

  // A source hits when it is read, is not x0, and names the rd of any live stage.
  function automatic logic [NUM_SRC-1:0] match(
    input logic [NUM_SRC*ADDR_W-1:0] rs,
    input logic [NUM_SRC-1:0]        used,
    input ld_stage_t [LOAD_LAT-1:0]  st
  );
    logic [NUM_SRC-1:0] hits;
    reg_addr_t          a;
    hits = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      a = reg_addr_t'(rs[i*ADDR_W +: ADDR_W]);
      for (int s = 0; s < LOAD_LAT; s++) begin
        if (used[i] && (a != '0) && st[s].valid && (st[s].rd == a)) begin
          hits[i] = 1'b1;
        end
      end
    end
    return hits;
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{valid: ld_valid_i, rd: reg_addr_t'(ld_rd_i)};
      for (int s = 1; s < LOAD_LAT; s++) begin
        stage_q[s] <= stage_q[s-1];
      end
    end
  end

  assign hit_o = match(rs_addr_i, rs_used_i, stage_q);

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard : load-use, scoreboard RAW/WAW and branch-flush control for decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = HZ_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*ADDR_W-1:0] id_rs_addr_i,
  input  logic [NUM_SRC-1:0]        id_rs_used_i,
  input  logic [ADDR_W-1:0]         id_rd_addr_i,
  input  logic                      id_rd_wen_i,
  input  logic                      id_mem_read_i,
  input  logic                      id_long_lat_i,
  input  logic                      lwb_valid_i,
  input  logic [ADDR_W-1:0]         lwb_rd_addr_i,
  input  logic                      branch_flush_i,
  output logic                      stall_if_o,
  output logic                      stall_id_o,
  output logic                      flush_id_o,
  output logic                      flush_ex_o,
  output logic [NUM_REGS-1:0]       sb_pending_o,
  output logic [CNT_W-1:0]          stall_cnt_o,
  output logic                      sb_err_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

  logic               raw_sb, waw_sb, load_use, hazard, issue;
  logic               rd_nz, ld_push;
  logic [NUM_SRC-1:0] ld_hit;

  assign rd_nz = (id_rd_addr_i != '0);

  always_comb begin
    raw_sb = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (id_rs_used_i[i] && (id_rs_addr_i[i*ADDR_W +: ADDR_W] != '0) &&
          pending_q[id_rs_addr_i[i*ADDR_W +: ADDR_W]]) begin
        raw_sb = 1'b1;
      end
    end
    raw_sb = raw_sb & id_valid_i;
  end

  assign waw_sb   = id_valid_i & id_rd_wen_i & rd_nz & pending_q[id_rd_addr_i];
  assign load_use = id_valid_i & (|ld_hit);
  assign hazard   = raw_sb | waw_sb | load_use;
  assign issue    = id_valid_i & ~hazard & ~branch_flush_i;
  assign ld_push  = issue & id_mem_read_i & id_rd_wen_i & rd_nz;

  hazard_load_window #(
    .LOAD_LAT (LOAD_LAT),
    .NUM_SRC  (NUM_SRC),
    .ADDR_W   (ADDR_W)
  ) u_load_window (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .ld_valid_i (ld_push),
    .ld_rd_i    (id_rd_addr_i),
    .rs_addr_i  (id_rs_addr_i),
    .rs_used_i  (id_rs_used_i),
    .hit_o      (ld_hit)
  );

  // Flush outranks any hazard: the instructions being stalled are about to be squashed.
  always_comb begin
    stall_if_o = 1'b0;
    stall_id_o = 1'b0;
    flush_id_o = 1'b0;
    flush_ex_o = 1'b0;
    if (branch_flush_i) begin
      flush_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end else if (hazard) begin
      stall_if_o = 1'b1;
      stall_id_o = 1'b1;
      flush_ex_o = 1'b1;
    end
  end

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    pending_d = pending_q;
    if (lwb_valid_i) begin
      pending_d[lwb_rd_addr_i] = 1'b0;
    end
    if (issue && id_long_lat_i && id_rd_wen_i && rd_nz) begin
      pending_d[id_rd_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_comb begin
    err_d = err_q;
    if (lwb_valid_i && ((lwb_rd_addr_i == '0) || !pending_q[lwb_rd_addr_i])) begin
      err_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_id_o && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign sb_pending_o = pending_q;
  assign stall_cnt_o  = cnt_q;
  assign sb_err_o     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard : random stimulus on two configurations against a timestamp-based model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: LOAD_LAT=1, 32-bit counter.  Instance 1: LOAD_LAT=3, 4-bit counter.
  logic                   id_valid  [2];
  logic [NS-1:0][AW-1:0]  rs_addr   [2];
  logic [NS-1:0]          rs_used   [2];
  logic [AW-1:0]          rd_addr   [2];
  logic                   rd_wen    [2];
  logic                   mem_read  [2];
  logic                   long_lat  [2];
  logic                   lwb_valid [2];
  logic [AW-1:0]          lwb_rd    [2];
  logic                   bflush    [2];
  logic                   st_if     [2];
  logic                   st_id     [2];
  logic                   fl_id     [2];
  logic                   fl_ex     [2];
  logic [NR-1:0]          pend      [2];
  logic                   err       [2];
  logic [31:0]            cnt_a;
  logic [3:0]             cnt_b;

  hazard_scoreboard #(.NUM_REGS(NR), .NUM_SRC(NS), .LOAD_LAT(1), .CNT_W(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid[0]), .id_rs_addr_i(rs_addr[0]), .id_rs_used_i(rs_used[0]),
    .id_rd_addr_i(rd_addr[0]), .id_rd_wen_i(rd_wen[0]), .id_mem_read_i(mem_read[0]),
    .id_long_lat_i(long_lat[0]), .lwb_valid_i(lwb_valid[0]), .lwb_rd_addr_i(lwb_rd[0]),
    .branch_flush_i(bflush[0]),
    .stall_if_o(st_if[0]), .stall_id_o(st_id[0]), .flush_id_o(fl_id[0]), .flush_ex_o(fl_ex[0]),
    .sb_pending_o(pend[0]), .stall_cnt_o(cnt_a), .sb_err_o(err[0])
  );

  hazard_scoreboard #(.NUM_REGS(NR), .NUM_SRC(NS), .LOAD_LAT(3), .CNT_W(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .id_valid_i(id_valid[1]), .id_rs_addr_i(rs_addr[1]), .id_rs_used_i(rs_used[1]),
    .id_rd_addr_i(rd_addr[1]), .id_rd_wen_i(rd_wen[1]), .id_mem_read_i(mem_read[1]),
    .id_long_lat_i(long_lat[1]), .lwb_valid_i(lwb_valid[1]), .lwb_rd_addr_i(lwb_rd[1]),
    .branch_flush_i(bflush[1]),
    .stall_if_o(st_if[1]), .stall_id_o(st_id[1]), .flush_id_o(fl_id[1]), .flush_ex_o(fl_ex[1]),
    .sb_pending_o(pend[1]), .stall_cnt_o(cnt_b), .sb_err_o(err[1])
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a load issued in cycle t blocks readers in cycles t+1 .. t+LAT.
  int      LAT  [2] = '{1, 3};
  longint  CMAX [2] = '{64'hFFFF_FFFF, 64'd15};
  bit      m_pend [2][NR];
  int      m_last [2][NR];
  int      m_cyc  [2];
  longint  m_cnt  [2];
  bit      m_err  [2];

  task automatic model_reset(input int k);
    for (int r = 0; r < NR; r++) begin
      m_pend[k][r] = 1'b0;
      m_last[k][r] = -100000;
    end
    m_cnt[k] = 0;
    m_err[k] = 1'b0;
  endtask

  task automatic drive_random(input int k, input bit in_reset);
    int q[$];
    id_valid[k] = ($urandom_range(0, 99) < 80);
    for (int i = 0; i < NS; i++) rs_addr[k][i] = AW'($urandom_range(0, 7));
    rs_used[k]  = NS'($urandom_range(0, 3));
    rd_addr[k]  = AW'($urandom_range(0, 7));
    rd_wen[k]   = ($urandom_range(0, 99) < 70);
    mem_read[k] = ($urandom_range(0, 99) < 25);
    long_lat[k] = ($urandom_range(0, 99) < 15);
    bflush[k]   = in_reset ? 1'b0 : ($urandom_range(0, 99) < 8);
    for (int r = 0; r < NR; r++) if (m_pend[k][r]) q.push_back(r);
    lwb_valid[k] = 1'b0;
    lwb_rd[k]    = '0;
    if (q.size() > 0 && $urandom_range(0, 99) < 35) begin
      lwb_valid[k] = 1'b1;
      lwb_rd[k]    = AW'(q[$urandom_range(0, q.size() - 1)]);
    end else if ($urandom_range(0, 199) < 2) begin
      lwb_valid[k] = 1'b1;
      lwb_rd[k]    = AW'($urandom_range(0, 7));
    end
  endtask

  task automatic eval_check_step(input int k, input bit in_reset);
    bit haz, raw, waw, lu, issue, e_sif, e_sid, e_fid, e_fex;
    logic [NR-1:0] pv;
    logic [63:0] got_cnt;
    int a, age;
    raw = 0; waw = 0; lu = 0;
    for (int i = 0; i < NS; i++) begin
      a = int'(rs_addr[k][i]);
      if (id_valid[k] && rs_used[k][i] && a != 0) begin
        if (m_pend[k][a]) raw = 1;
        age = m_cyc[k] - m_last[k][a];
        if (age >= 1 && age <= LAT[k]) lu = 1;
      end
    end
    if (id_valid[k] && rd_wen[k] && rd_addr[k] != 0 && m_pend[k][int'(rd_addr[k])]) waw = 1;
    haz = raw | waw | lu;
    e_fid = bflush[k];
    e_fex = bflush[k] | haz;
    e_sif = !bflush[k] & haz;
    e_sid = e_sif;
    for (int r = 0; r < NR; r++) pv[r] = m_pend[k][r];
    got_cnt = (k == 0) ? 64'(cnt_a) : 64'(cnt_b);

    check($sformatf("stall_if[%0d]", k), 64'(st_if[k]), 64'(e_sif));
    check($sformatf("stall_id[%0d]", k), 64'(st_id[k]), 64'(e_sid));
    check($sformatf("flush_id[%0d]", k), 64'(fl_id[k]), 64'(e_fid));
    check($sformatf("flush_ex[%0d]", k), 64'(fl_ex[k]), 64'(e_fex));
    check($sformatf("pending[%0d]", k),  64'(pend[k]),  64'(pv));
    check($sformatf("stall_cnt[%0d]", k), got_cnt, 64'(m_cnt[k]));
    check($sformatf("sb_err[%0d]", k),   64'(err[k]),   64'(m_err[k]));

    if (!in_reset) begin
      issue = id_valid[k] && !haz && !bflush[k];
      if (lwb_valid[k] && (lwb_rd[k] == 0 || !m_pend[k][int'(lwb_rd[k])])) m_err[k] = 1'b1;
      if (lwb_valid[k] && lwb_rd[k] != 0) m_pend[k][int'(lwb_rd[k])] = 1'b0;
      if (issue && long_lat[k] && rd_wen[k] && rd_addr[k] != 0) m_pend[k][int'(rd_addr[k])] = 1'b1;
      if (issue && mem_read[k] && rd_wen[k] && rd_addr[k] != 0) m_last[k][int'(rd_addr[k])] = m_cyc[k];
      if (e_sid && m_cnt[k] < CMAX[k]) m_cnt[k]++;
    end
    m_cyc[k]++;
  endtask

  task automatic run_cycle(input bit in_reset);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) drive_random(k, in_reset);
    @(negedge clk);
    for (int k = 0; k < 2; k++) eval_check_step(k, in_reset);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      m_cyc[k] = 0;
      drive_random(k, 1'b1);
    end
    rst_n = 1'b0;
    run_cycle(1'b1);
    run_cycle(1'b1);
    for (int ep = 0; ep < 5; ep++) begin
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 2; k++) eval_check_step(k, 1'b0);
      for (int c = 0; c < 300; c++) run_cycle(1'b0);
      // Asynchronous reset mid-operation: state must clear before the next edge.
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
        model_reset(k);
        drive_random(k, 1'b1);
      end
      @(negedge clk);
      for (int k = 0; k < 2; k++) eval_check_step(k, 1'b1);
      run_cycle(1'b1);
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
